// File: rtl/morse_pkg.sv
// Shared types and constants for the ASCII-to-Morse keyer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MARK,
    EGAP,
    LGAP,
    WGAP
  } state_t;

  localparam int unsigned DOT_UNITS  = 1;
  localparam int unsigned DASH_UNITS = 3;
  localparam int unsigned EGAP_UNITS = 1;
  localparam int unsigned LGAP_UNITS = 3;
  localparam int unsigned WGAP_EXTRA = 4;

  localparam logic [7:0] SPACE_CODE = 8'hE0;

  // Lower-case letters share the upper-case ROM entries; bytes above 0x7F
  // are steered to address 0, which is unsupported.
  function automatic logic [6:0] fold_addr(input logic [7:0] c);
    logic [6:0] a;
    if (c[7]) begin
      a = 7'h00;
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      a = {c[6], 1'b0, c[4:0]};
    end else begin
      a = c[6:0];
    end
    return a;
  endfunction

  function automatic logic [2:0] mark_units(input logic is_dash);
    return is_dash ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
  endfunction

endpackage

// File: rtl/ascii_morse_rom.sv
// Synchronous 128x8 Morse lookup ROM: {len[2:0], pat[4:0]}, 1 = dash,
// elements keyed from pat[len-1] down to pat[0]. Unsupported codes read 0.
module ascii_morse_rom (
  input  logic       clk,
  input  logic [6:0] addr,
  output logic [7:0] data
);

  function automatic logic [7:0] lookup(input logic [6:0] a);
    logic [7:0] w;
    w = '0;
    case (a)
      7'h20: w = {3'd7, 5'b00000};
      7'h30: w = {3'd5, 5'b11111};
      7'h31: w = {3'd5, 5'b01111};
      7'h32: w = {3'd5, 5'b00111};
      7'h33: w = {3'd5, 5'b00011};
      7'h34: w = {3'd5, 5'b00001};
      7'h35: w = {3'd5, 5'b00000};
      7'h36: w = {3'd5, 5'b10000};
      7'h37: w = {3'd5, 5'b11000};
      7'h38: w = {3'd5, 5'b11100};
      7'h39: w = {3'd5, 5'b11110};
      7'h41: w = {3'd2, 5'b00001};
      7'h42: w = {3'd4, 5'b01000};
      7'h43: w = {3'd4, 5'b01010};
      7'h44: w = {3'd3, 5'b00100};
      7'h45: w = {3'd1, 5'b00000};
      7'h46: w = {3'd4, 5'b00010};
      7'h47: w = {3'd3, 5'b00110};
      7'h48: w = {3'd4, 5'b00000};
      7'h49: w = {3'd2, 5'b00000};
      7'h4A: w = {3'd4, 5'b00111};
      7'h4B: w = {3'd3, 5'b00101};
      7'h4C: w = {3'd4, 5'b00100};
      7'h4D: w = {3'd2, 5'b00011};
      7'h4E: w = {3'd2, 5'b00010};
      7'h4F: w = {3'd3, 5'b00111};
      7'h50: w = {3'd4, 5'b00110};
      7'h51: w = {3'd4, 5'b01101};
      7'h52: w = {3'd3, 5'b00010};
      7'h53: w = {3'd3, 5'b00000};
      7'h54: w = {3'd1, 5'b00001};
      7'h55: w = {3'd3, 5'b00001};
      7'h56: w = {3'd4, 5'b00001};
      7'h57: w = {3'd3, 5'b00011};
      7'h58: w = {3'd4, 5'b01001};
      7'h59: w = {3'd4, 5'b01011};
      7'h5A: w = {3'd4, 5'b01100};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Registered read: data is valid one cycle after addr.
  always_ff @(posedge clk) begin
    data <= lookup(addr);
  end

endmodule

// File: rtl/ascii2morse.sv
// Pops characters from the UART RX FIFO and keys them out as Morse with
// standard unit timing (dot 1, dash 3, element gap 1, letter gap 3, word 7).
module ascii2morse
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = 6_000_000,
  parameter int unsigned CNT_W      = $clog2(UNIT_TICKS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       rd_uart,
  output logic       morse_out,
  output logic       busy
);

  state_t           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       unit_q, unit_d;
  logic [2:0]       idx_q, idx_d;
  logic             morse_q, morse_d;
  logic             busy_q, busy_d;

  logic [6:0]       rom_addr;
  logic [7:0]       rom_data;
  logic [2:0]       rom_len;
  logic [4:0]       rom_pat;
  logic             tick_last;
  logic             timed_done;

  assign rom_addr   = fold_addr(char_q);
  assign rom_len    = rom_data[7:5];
  assign rom_pat    = rom_data[4:0];
  assign tick_last  = (tick_q == CNT_W'(UNIT_TICKS - 1));
  assign timed_done = tick_last && (unit_q == 3'd1);

  // char_q is stable from FETCH onward, so the ROM word stays valid for the
  // whole character and pat can be indexed directly in every timed state.
  ascii_morse_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      char_q  <= '0;
      tick_q  <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      morse_q <= morse_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; entering a timed state reloads tick/unit counters.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    idx_d   = idx_q;

    if (state_q inside {MARK, EGAP, LGAP, WGAP}) begin
      if (tick_last) begin
        tick_d = '0;
        unit_d = unit_q - 3'd1;
      end else begin
        tick_d = tick_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          char_d  = r_data;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        tick_d = '0;
        if (rom_data == SPACE_CODE) begin
          state_d = WGAP;
          unit_d  = 3'(WGAP_EXTRA);
        end else if (rom_len == 3'd0 || rom_len > 3'd5) begin
          state_d = IDLE;
        end else begin
          state_d = MARK;
          idx_d   = rom_len - 3'd1;
          unit_d  = mark_units(rom_pat[rom_len - 3'd1]);
        end
      end
      MARK: begin
        if (timed_done) begin
          tick_d = '0;
          if (idx_q == 3'd0) begin
            state_d = LGAP;
            unit_d  = 3'(LGAP_UNITS);
          end else begin
            state_d = EGAP;
            unit_d  = 3'(EGAP_UNITS);
          end
        end
      end
      EGAP: begin
        if (timed_done) begin
          state_d = MARK;
          tick_d  = '0;
          idx_d   = idx_q - 3'd1;
          unit_d  = mark_units(rom_pat[idx_q - 3'd1]);
        end
      end
      LGAP, WGAP: begin
        if (timed_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop strobe and next values of the registered key/busy outputs.
  always_comb begin
    rd_uart = (state_q == IDLE) && !rx_empty && !reset;
    morse_d = (state_d == MARK);
    busy_d  = (state_d != IDLE);
  end

  assign morse_out = morse_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascii2morse.sv
module tb_ascii2morse;

  localparam int unsigned UT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic       morse_out;
  logic       busy;

  ascii2morse #(.UNIT_TICKS(UT)) dut (
    .clk       (clk),
    .reset     (reset),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rd_uart   (rd_uart),
    .morse_out (morse_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_bad   = 0;
  int idle_bad = 0;
  int late_bad = 0;

  // FIFO contents and scoreboard of expected per-character traces.
  logic [7:0] fifo[$];
  logic [7:0] exp_ch[$];
  bit         exp_ab[$];
  string      exp_m[$];
  string      exp_b[$];

  bit         active = 1'b0;

  string ltab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                      "-.--", "--.."};
  string dtab[10] = '{"-----", ".----", "..---", "...--", "....-",
                      ".....", "-....", "--...", "---..", "----."};

  function automatic string code_of(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return ltab[int'(c) - 65];
    if (c >= 8'h61 && c <= 8'h7A) return ltab[int'(c) - 97];
    if (c >= 8'h30 && c <= 8'h39) return dtab[int'(c) - 48];
    if (c == 8'h20) return " ";
    return "";
  endfunction

  function automatic string rep(input string ch, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, ch};
    return s;
  endfunction

  // Expected morse_out / busy traces for the cycles after the pop cycle,
  // ending with the first cycle back in idle.
  task automatic build(input logic [7:0] c, output string m, output string b);
    string code;
    code = code_of(c);
    m = "00";
    if (code == " ") begin
      m = {m, rep("0", 4 * UT)};
    end else begin
      for (int i = 0; i < code.len(); i++) begin
        m = {m, rep("1", (code[i] == 8'h2D) ? 3 * UT : UT)};
        m = {m, rep("0", (i == code.len() - 1) ? 3 * UT : UT)};
      end
    end
    m = {m, "0"};
    b = {rep("1", m.len() - 1), "0"};
  endtask

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic chks(input string name, input string act, input string want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%s want=%s", name, act, want);
    end
  endtask

  task automatic push_char(input logic [7:0] c);
    string m, b;
    build(c, m, b);
    fifo.push_back(c);
    exp_ch.push_back(c);
    exp_ab.push_back(1'b0);
    exp_m.push_back(m);
    exp_b.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_ch.size() != 0 || active || fifo.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout waited=%0d pending=%0d", n, exp_ch.size());
    end
    @(negedge clk);
  endtask

  // FIFO model: a pop seen before the edge removes the head after it.
  initial begin : driver
    bit pend;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      pend = rd_uart;
      @(posedge clk);
      #1;
      if (pend && fifo.size() > 0) void'(fifo.pop_front());
      if (fifo.size() > 0) begin
        rx_empty = 1'b0;
        r_data   = fifo[0];
      end else begin
        rx_empty = 1'b1;
        r_data   = 8'h00;
      end
    end
  end

  // Monitor: on each pop, take the next expected trace and compare.
  initial begin : monitor
    string am, ab, em, eb;
    logic [7:0] cur;
    bit   cur_abort;
    int   rem;
    rem = 0;
    cur = 8'h00;
    cur_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else begin
        if (rd_uart && rx_empty) rd_bad++;
        if (active) begin
          if (!cur_abort) begin
            if (morse_out) am = {am, "1"}; else am = {am, "0"};
            if (busy) ab = {ab, "1"}; else ab = {ab, "0"};
            if (rem > 1 && rd_uart) rd_bad++;
            rem--;
            if (rem == 0) begin
              chks($sformatf("morse[%02h]", cur), am, em);
              chks($sformatf("busy[%02h]", cur), ab, eb);
              if (!rx_empty && !rd_uart) late_bad++;
              active = 1'b0;
            end
          end
        end else if (morse_out || busy) begin
          idle_bad++;
        end
        if (!active && rd_uart) begin
          if (exp_ch.size() == 0) begin
            chk("unexpected_pop", int'(r_data), -1);
          end else begin
            cur       = exp_ch.pop_front();
            cur_abort = exp_ab.pop_front();
            em        = exp_m.pop_front();
            eb        = exp_b.pop_front();
            chk("pop_char", int'(r_data), int'(cur));
            am     = "";
            ab     = "";
            rem    = em.len();
            active = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int sel;
    logic [7:0] c;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_morse", int'(morse_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd", int'(rd_uart), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    push_char(8'h45);
    wait_drain(500);
    push_char(8'h61);
    push_char(8'h41);
    wait_drain(500);
    push_char(8'h53);
    push_char(8'h4F);
    push_char(8'h53);
    wait_drain(1000);
    push_char(8'h54);
    push_char(8'h20);
    wait_drain(500);
    push_char(8'h23);
    push_char(8'h45);
    wait_drain(500);

    // Abort '0' during its first dash; the next entry must be keyed normally.
    fifo.push_back(8'h30);
    exp_ch.push_back(8'h30);
    exp_ab.push_back(1'b1);
    exp_m.push_back("");
    exp_b.push_back("");
    n = 0;
    while (!morse_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_mark_seen", int'(morse_out), 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_morse", int'(morse_out), 0);
    chk("abort_busy", int'(busy), 0);
    push_char(8'h4B);
    @(negedge clk);
    chk("abort_rd_held", int'(rd_uart), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_drain(500);

    repeat (40) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      c = 8'(8'h41 + $urandom_range(0, 25));
      else if (sel <= 5) c = 8'(8'h61 + $urandom_range(0, 25));
      else if (sel == 6) c = 8'(8'h30 + $urandom_range(0, 9));
      else if (sel == 7) c = 8'h20;
      else               c = 8'($urandom_range(0, 127));
      push_char(c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 120)) @(negedge clk);
    end
    wait_drain(20000);

    chk("rd_outside_idle", rd_bad, 0);
    chk("active_when_untracked", idle_bad, 0);
    chk("late_pop", late_bad, 0);
    chk("pending_expect", exp_ch.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
